// File: rtl/id_ctrl_decode.sv
// Decode-stage control: field decode, second read-port select, bubble
// gating and the ID/EX control pipeline register.
module id_ctrl_decode #(
   parameter int CTRL_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_bit,
   input  logic [1:0]        mode,
   input  logic [3:0]        opcode,
   input  logic [3:0]        rm,
   input  logic [3:0]        rd,
   input  logic              cond_ok,
   input  logic              hazard,
   input  logic              flush,
   output logic [3:0]        src2,
   output logic              two_src,
   output logic [CTRL_W-1:0] ctrl_bundle,
   output logic              wb_en_ex,
   output logic              mem_read_ex,
   output logic              mem_write_ex,
   output logic              b_ex,
   output logic              s_ex,
   output logic [3:0]        exe_cmd_ex
);

   logic       s_dec;
   logic       b_dec;
   logic       mw_dec;
   logic       mr_dec;
   logic       wb_dec;
   logic [3:0] cmd_dec;
   logic       sel;

   always_comb begin
      s_dec   = 1'b0;
      b_dec   = 1'b0;
      mw_dec  = 1'b0;
      mr_dec  = 1'b0;
      wb_dec  = 1'b0;
      cmd_dec = 4'b0000;
      unique case (mode)
         2'b00: begin
            s_dec = s_bit;
            case (opcode)
               4'b1101: begin cmd_dec = 4'b0001; wb_dec = 1'b1; end
               4'b1111: begin cmd_dec = 4'b1001; wb_dec = 1'b1; end
               4'b0100: begin cmd_dec = 4'b0010; wb_dec = 1'b1; end
               4'b0101: begin cmd_dec = 4'b0011; wb_dec = 1'b1; end
               4'b0010: begin cmd_dec = 4'b0100; wb_dec = 1'b1; end
               4'b0110: begin cmd_dec = 4'b0101; wb_dec = 1'b1; end
               4'b0000: begin cmd_dec = 4'b0110; wb_dec = 1'b1; end
               4'b1100: begin cmd_dec = 4'b0111; wb_dec = 1'b1; end
               4'b0001: begin cmd_dec = 4'b1000; wb_dec = 1'b1; end
               4'b1010: cmd_dec = 4'b0100;
               4'b1000: cmd_dec = 4'b0110;
               default: s_dec = 1'b0;
            endcase
         end
         2'b01: begin
            cmd_dec = 4'b0010;
            mr_dec  = s_bit;
            wb_dec  = s_bit;
            mw_dec  = ~s_bit;
         end
         2'b10: b_dec = 1'b1;
         default: ;
      endcase
   end

   // STR reads its data register through the second port
   assign src2    = mw_dec ? rd : rm;
   assign two_src = mw_dec | (mode == 2'b00);

   assign sel = ~cond_ok | hazard;

   always_comb begin
      ctrl_bundle = '0;
      if (!sel)
         ctrl_bundle = {s_dec, b_dec, cmd_dec, mw_dec, mr_dec, wb_dec};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_ex         <= 1'b0;
         b_ex         <= 1'b0;
         exe_cmd_ex   <= 4'b0000;
         mem_write_ex <= 1'b0;
         mem_read_ex  <= 1'b0;
         wb_en_ex     <= 1'b0;
      end else if (flush) begin
         s_ex         <= 1'b0;
         b_ex         <= 1'b0;
         exe_cmd_ex   <= 4'b0000;
         mem_write_ex <= 1'b0;
         mem_read_ex  <= 1'b0;
         wb_en_ex     <= 1'b0;
      end else begin
         {s_ex, b_ex, exe_cmd_ex, mem_write_ex, mem_read_ex, wb_en_ex}
            <= ctrl_bundle[8:0];
      end
   end

endmodule

// File: tb/tb_id_ctrl_decode.sv
// Directed bench for id_ctrl_decode: decode, src2 select, gating,
// flush and asynchronous reset of the EX control register.
module tb_id_ctrl_decode;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_bit;
   logic [1:0] mode;
   logic [3:0] opcode;
   logic [3:0] rm;
   logic [3:0] rd;
   logic       cond_ok;
   logic       hazard;
   logic       flush;
   logic [3:0] src2;
   logic       two_src;
   logic [8:0] ctrl_bundle;
   logic       wb_en_ex;
   logic       mem_read_ex;
   logic       mem_write_ex;
   logic       b_ex;
   logic       s_ex;
   logic [3:0] exe_cmd_ex;

   int checks = 0;
   int errors = 0;

   id_ctrl_decode #(.CTRL_W(9)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_bit        (s_bit),
      .mode         (mode),
      .opcode       (opcode),
      .rm           (rm),
      .rd           (rd),
      .cond_ok      (cond_ok),
      .hazard       (hazard),
      .flush        (flush),
      .src2         (src2),
      .two_src      (two_src),
      .ctrl_bundle  (ctrl_bundle),
      .wb_en_ex     (wb_en_ex),
      .mem_read_ex  (mem_read_ex),
      .mem_write_ex (mem_write_ex),
      .b_ex         (b_ex),
      .s_ex         (s_ex),
      .exe_cmd_ex   (exe_cmd_ex)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ex_vec();
      return {s_ex, b_ex, exe_cmd_ex, mem_write_ex, mem_read_ex, wb_en_ex};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs,
                        input logic [8:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] m, input logic [3:0] op,
                        input logic s, input logic [3:0] a,
                        input logic [3:0] d, input logic c,
                        input logic h, input logic f);
      mode = m; opcode = op; s_bit = s; rm = a; rd = d;
      cond_ok = c; hazard = h; flush = f;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(2'b00, 4'b0100, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
      #1;
      check("reset_ex", ex_vec(), 9'b0);
      check("reset_comb", ctrl_bundle, 9'b1_0_0010_0_0_1);
      edge_step();
      check("reset_hold", ex_vec(), 9'b0);
      @(negedge clk);
      rst = 1'b1;

      check("add_bundle", ctrl_bundle, 9'b1_0_0010_0_0_1);
      check("add_src2", {5'b0, src2}, 9'd5);
      check("add_two_src", {8'b0, two_src}, 9'd1);
      edge_step();
      check("add_ex", ex_vec(), 9'b1_0_0010_0_0_1);

      #2 rst = 1'b0;
      #1;
      check("async_reset", ex_vec(), 9'b0);
      edge_step();
      check("reset_over_edge", ex_vec(), 9'b0);
      @(negedge clk);
      rst = 1'b1;

      drive(2'b00, 4'b1010, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0);
      #1;
      check("cmp_bundle", ctrl_bundle, 9'b1_0_0100_0_0_0);
      edge_step();
      check("cmp_ex", ex_vec(), 9'b1_0_0100_0_0_0);

      @(negedge clk);
      drive(2'b00, 4'b1111, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0);
      #1;
      check("mvn_bundle", ctrl_bundle, 9'b0_0_1001_0_0_1);
      edge_step();
      check("mvn_ex", ex_vec(), 9'b0_0_1001_0_0_1);

      @(negedge clk);
      drive(2'b01, 4'b0100, 1'b0, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      #1;
      check("str_bundle", ctrl_bundle, 9'b0_0_0010_1_0_0);
      check("str_src2", {5'b0, src2}, 9'd7);
      check("str_two_src", {8'b0, two_src}, 9'd1);
      edge_step();
      check("str_ex", ex_vec(), 9'b0_0_0010_1_0_0);

      @(negedge clk);
      drive(2'b01, 4'b1100, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      #1;
      check("ldr_bundle", ctrl_bundle, 9'b0_0_0010_0_1_1);
      check("ldr_src2", {5'b0, src2}, 9'd3);
      check("ldr_two_src", {8'b0, two_src}, 9'd0);
      edge_step();
      check("ldr_ex", ex_vec(), 9'b0_0_0010_0_1_1);

      @(negedge clk);
      drive(2'b10, 4'b0100, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      #1;
      check("branch_bundle", ctrl_bundle, 9'b0_1_0000_0_0_0);
      edge_step();
      check("branch_ex", ex_vec(), 9'b0_1_0000_0_0_0);

      @(negedge clk);
      drive(2'b00, 4'b0011, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      #1;
      check("unlisted_op", ctrl_bundle, 9'b0);
      check("unlisted_two_src", {8'b0, two_src}, 9'd1);
      drive(2'b11, 4'b0100, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      #1;
      check("mode11", ctrl_bundle, 9'b0);

      @(negedge clk);
      drive(2'b00, 4'b0100, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0);
      #1;
      check("cond_fail_bundle", ctrl_bundle, 9'b0);
      edge_step();
      check("cond_fail_ex", ex_vec(), 9'b0);

      @(negedge clk);
      drive(2'b00, 4'b0100, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
      edge_step();
      check("add_reload_ex", ex_vec(), 9'b1_0_0010_0_0_1);
      @(negedge clk);
      hazard = 1'b1;
      #1;
      check("hazard_bundle", ctrl_bundle, 9'b0);
      edge_step();
      check("hazard_ex", ex_vec(), 9'b0);

      @(negedge clk);
      drive(2'b01, 4'b0000, 1'b0, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0);
      #1;
      check("hazard_str_bundle", ctrl_bundle, 9'b0);
      check("hazard_str_src2", {5'b0, src2}, 9'd7);

      @(negedge clk);
      drive(2'b00, 4'b0100, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
      edge_step();
      check("pre_flush_ex", ex_vec(), 9'b1_0_0010_0_0_1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_bundle", ctrl_bundle, 9'b1_0_0010_0_0_1);
      edge_step();
      check("flush_ex", ex_vec(), 9'b0);

      @(negedge clk);
      drive(2'b00, 4'b0100, 1'b1, 4'd5, 4'd9, 1'b1, 1'b1, 1'b1);
      edge_step();
      check("hazard_flush_ex", ex_vec(), 9'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
